// File: rtl/mock_hash_engine.sv
// Stand-in for the SHA-256d core: folds a 352-bit state into a 256-bit pseudo-hash and reports its leading-zero count after LATENCY cycles.
// Latency LATENCY cycles. One beat is accepted per II cycles, and a beat offered while readyOut=0 is dropped and flagged in overrun.
module mock_hash_engine #(
    parameter int LATENCY = 10,
    parameter int II      = 1,
    parameter int HCW     = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           validIn,
    input  logic           newBlockIn,
    input  logic [351:0]   initialState,
    input  logic [8:0]     target,
    output logic           readyOut,
    output logic           validOut,
    output logic           newBlockOut,
    output logic [255:0]   hash,
    output logic [31:0]    difficulty,
    output logic           hit,
    output logic [HCW-1:0] hitCount,
    output logic           overrun
);

    localparam int CW = 5;

    function automatic logic [8:0] lzc256(input logic [255:0] h);
        logic [8:0] n;
        logic       found;
        n     = '0;
        found = 1'b0;
        for (int i = 255; i >= 0; i--) begin
            if (!found) begin
                if (h[i]) found = 1'b1;
                else      n     = n + 9'd1;
            end
        end
        return n;
    endfunction

    logic [CW-1:0] r_cnt;
    logic          r_overrun;
    logic [HCW-1:0] r_hit_cnt;

    logic          r_vld  [LATENCY];
    logic          r_nb   [LATENCY];
    logic [255:0]  r_hash [LATENCY];
    logic [8:0]    r_lzc  [LATENCY];

    logic          w_accept;
    logic [255:0]  w_fold;
    logic [8:0]    w_lzc;
    logic          w_hit;

    assign readyOut = (r_cnt == '0);
    assign w_accept = validIn && readyOut;
    assign w_fold   = initialState[255:0] ^ {160'b0, initialState[351:256]};
    assign w_lzc    = lzc256(w_fold);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept && (II > 1)) begin
            r_cnt <= CW'(II - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
        end else if (validIn && !readyOut) begin
            r_overrun <= 1'b1;
        end
    end

    // Valid/newBlock shift every cycle; payload loads only behind a valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_vld[k]  <= 1'b0;
                r_nb[k]   <= 1'b0;
                r_hash[k] <= '0;
                r_lzc[k]  <= '0;
            end
        end else begin
            r_vld[0] <= w_accept;
            r_nb[0]  <= newBlockIn && w_accept;
            if (w_accept) begin
                r_hash[0] <= w_fold;
                r_lzc[0]  <= w_lzc;
            end
            for (int k = 1; k < LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_nb[k]  <= r_nb[k-1];
                if (r_vld[k-1]) begin
                    r_hash[k] <= r_hash[k-1];
                    r_lzc[k]  <= r_lzc[k-1];
                end
            end
        end
    end

    assign w_hit = r_vld[LATENCY-1] && (r_lzc[LATENCY-1] >= target);

    // A new-block beat restarts the count at its own hit, not on top of the old count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt <= '0;
        end else if (r_vld[LATENCY-1] && r_nb[LATENCY-1]) begin
            r_hit_cnt <= {{(HCW-1){1'b0}}, w_hit};
        end else if (w_hit && !(&r_hit_cnt)) begin
            r_hit_cnt <= r_hit_cnt + 1'b1;
        end
    end

    assign validOut    = r_vld[LATENCY-1];
    assign newBlockOut = r_nb[LATENCY-1];
    assign hash        = r_hash[LATENCY-1];
    assign difficulty  = {23'b0, r_lzc[LATENCY-1]};
    assign hit         = w_hit;
    assign hitCount    = r_hit_cnt;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_mock_hash_engine.sv
// Directed bench for mock_hash_engine: A (L=10, II=1), B (L=10, II=4, HCW=2), C (L=1, II=1).
module tb_mock_hash_engine;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         nb_in = 1'b0;
    logic [351:0] st = '0;
    logic [8:0]   tgt = '0;
    logic         va = 1'b0, vb = 1'b0, vc = 1'b0;

    logic         a_rdy, a_vld, a_nb, a_hit, a_ovr;
    logic [255:0] a_hash;
    logic [31:0]  a_diff;
    logic [15:0]  a_hc;
    logic         b_rdy, b_vld, b_nb, b_hit, b_ovr;
    logic [255:0] b_hash;
    logic [31:0]  b_diff;
    logic [1:0]   b_hc;
    logic         c_rdy, c_vld, c_nb, c_hit, c_ovr;
    logic [255:0] c_hash;
    logic [31:0]  c_diff;
    logic [15:0]  c_hc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mock_hash_engine #(.LATENCY(10), .II(1), .HCW(16)) u_a (
        .clk(clk), .rst(rst), .validIn(va), .newBlockIn(nb_in), .initialState(st), .target(tgt),
        .readyOut(a_rdy), .validOut(a_vld), .newBlockOut(a_nb), .hash(a_hash), .difficulty(a_diff),
        .hit(a_hit), .hitCount(a_hc), .overrun(a_ovr));

    mock_hash_engine #(.LATENCY(10), .II(4), .HCW(2)) u_b (
        .clk(clk), .rst(rst), .validIn(vb), .newBlockIn(nb_in), .initialState(st), .target(tgt),
        .readyOut(b_rdy), .validOut(b_vld), .newBlockOut(b_nb), .hash(b_hash), .difficulty(b_diff),
        .hit(b_hit), .hitCount(b_hc), .overrun(b_ovr));

    mock_hash_engine #(.LATENCY(1), .II(1), .HCW(16)) u_c (
        .clk(clk), .rst(rst), .validIn(vc), .newBlockIn(nb_in), .initialState(st), .target(tgt),
        .readyOut(c_rdy), .validOut(c_vld), .newBlockOut(c_nb), .hash(c_hash), .difficulty(c_diff),
        .hit(c_hit), .hitCount(c_hc), .overrun(c_ovr));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [351:0] obs, input logic [351:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] ref_fold(input logic [351:0] s);
        return s[255:0] ^ {160'b0, s[351:256]};
    endfunction

    function automatic logic [31:0] ref_lz(input logic [255:0] h);
        int n = 0;
        while (n < 256 && h[255-n] == 1'b0) n++;
        return 32'(n);
    endfunction

    logic [255:0] exp_h;
    logic [31:0]  exp_d;
    logic         exp_nb;
    int           pulses;

    initial begin
        // Reset state
        #12;
        check("rst_ready", a_rdy, 1);
        check("rst_valid", a_vld, 0);
        check("rst_nb", a_nb, 0);
        check("rst_hash", a_hash, 0);
        check("rst_diff", a_diff, 0);
        check("rst_hit", a_hit, 0);
        check("rst_hitcnt", a_hc, 0);
        check("rst_overrun", a_ovr, 0);
        rst = 1'b0;
        tick();

        // Single beat through L=10: hash=1, difficulty=255
        st = '0; st[0] = 1'b1; va = 1'b1;
        tick();
        va = 1'b0;
        for (int i = 2; i <= 10; i++) begin
            tick();
            check("t1_valid_timing", a_vld, (i == 10));
            check("t1_ready_high", a_rdy, 1);
        end
        check("t1_hash", a_hash, 1);
        check("t1_diff", a_diff, 255);
        tick();
        check("t1_one_cycle", a_vld, 0);

        // Zero hash -> difficulty 256, hit at target 256
        tgt = 9'd256;
        st = '0; st[0] = 1'b1; st[256] = 1'b1; va = 1'b1;
        tick();
        va = 1'b0;
        repeat (9) tick();
        check("t2_valid", a_vld, 1);
        check("t2_hash_zero", a_hash, 0);
        check("t2_diff256", a_diff, 256);
        check("t2_hit256", a_hit, 1);

        // MSB set -> difficulty 0, hit only at target 0; target acts same cycle
        tgt = 9'd0;
        st = '0; st[255] = 1'b1; va = 1'b1;
        tick();
        va = 1'b0;
        repeat (9) tick();
        check("t3_diff0", a_diff, 0);
        check("t3_hit_t0", a_hit, 1);
        tgt = 9'd1;
        #1;
        check("t3_hit_t1", a_hit, 0);

        // Hit counting: 5 back-to-back hits, first with newBlock
        tgt = 9'd8;
        for (int t = 1; t <= 16; t++) begin
            if (t <= 5) begin
                va = 1'b1; nb_in = (t == 1); st = '0; st[t] = 1'b1;
            end else begin
                va = 1'b0; nb_in = 1'b0;
            end
            tick();
            if (t == 10) begin
                check("t4_nb_out", a_nb, 1);
                check("t4_diff", a_diff, 254);
            end
            if (t >= 11 && t <= 15) check("t4_hitcount", a_hc, 16'(t - 10));
        end
        // newBlock beat with difficulty 3 under target 8 restarts count at 0
        st = '0; st[252] = 1'b1; va = 1'b1; nb_in = 1'b1;
        tick();
        va = 1'b0; nb_in = 1'b0;
        repeat (9) tick();
        check("t5_diff3", a_diff, 3);
        check("t5_nb_out", a_nb, 1);
        check("t5_nohit", a_hit, 0);
        tick();
        check("t5_hitcount0", a_hc, 0);

        // HCW=2 saturation on B with six spaced hits
        for (int b = 0; b < 6; b++) begin
            st = '0; st[0] = 1'b1; vb = 1'b1; nb_in = (b == 0);
            tick();
            vb = 1'b0; nb_in = 1'b0;
            if (b == 0) check("t6_ready_drop", b_rdy, 0);
            repeat (3) tick();
        end
        repeat (12) tick();
        check("t6_saturate", b_hc, 3);
        check("t6_no_overrun", b_ovr, 0);

        // II=4 with validIn held for 12 cycles
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            vb = (c < 12);
            if (c < 12) begin
                check("t7_ready_pattern", b_rdy, (c % 4 == 0));
                check("t7_overrun", b_ovr, (c >= 2));
            end
            tick();
            if (b_vld) pulses++;
        end
        vb = 1'b0;
        check("t7_accepts", pulses, 3);

        // Reset with beats in flight and one on the outputs
        for (int t = 1; t <= 11; t++) begin
            va = (t <= 5); nb_in = (t == 1); st = '0; st[0] = 1'b1;
            tick();
        end
        va = 1'b0; nb_in = 1'b0;
        check("t8_pre_valid", a_vld, 1);
        check("t8_pre_hc", a_hc, 1);
        #2 rst = 1'b1;
        #1;
        check("t8_valid", a_vld, 0);
        check("t8_nb", a_nb, 0);
        check("t8_hash", a_hash, 0);
        check("t8_diff", a_diff, 0);
        check("t8_hit", a_hit, 0);
        check("t8_hc", a_hc, 0);
        check("t8_ready", a_rdy, 1);
        check("t8_b_overrun", b_ovr, 0);
        check("t8_b_hc", b_hc, 0);
        #3 rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (a_vld) pulses++;
        end
        check("t8_no_ghost", pulses, 0);

        // L=1 random stream on C
        for (int i = 0; i < 20; i++) begin
            for (int w = 0; w < 11; w++) st[w*32 +: 32] = $urandom;
            if (i % 3 == 0) st[255:0] = st[255:0] >> $urandom_range(0, 255);
            if (i == 5) st = '0;
            nb_in = 1'($urandom_range(0, 1));
            vc = 1'b1;
            exp_h = ref_fold(st);
            exp_d = ref_lz(exp_h);
            exp_nb = nb_in;
            tick();
            check("t9_valid", c_vld, 1);
            check("t9_hash", c_hash, exp_h);
            check("t9_diff", c_diff, exp_d);
            check("t9_nb", c_nb, exp_nb);
        end
        vc = 1'b0; nb_in = 1'b0;
        tick();
        check("t9_idle", c_vld, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mock_hash_engine.md
# mock_hash_engine

Parametrised stand-in for the SHA-256d mining core, used to bring up and test the nonce dispatcher, result collector and difficulty logic before the real hash pipeline is available. It folds the 352-bit initial state into a 256-bit pseudo-hash and delays it by a configurable latency. It adds an initiation-interval mode with backpressure, a real difficulty measure (leading-zero count), a target comparison and a per-block hit counter. Drop-in position: between the nonce generator and the result collector.

## Interface
- LATENCY, 10: pipeline depth in cycles from accepted input to output; legal range 1..64.
- II, 1: initiation interval; minimum cycles between accepted inputs; legal range 1..16.
- HCW, 16: width of hitCount.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- validIn  in  1  input beat present.
- newBlockIn  in  1  first beat of a new block; meaningful only with validIn.
- initialState  in  352  state to hash.
- target  in  9  required leading-zero count, 0..256; quasi-static.
- readyOut  out  1  engine can accept a beat this cycle.
- validOut  out  1  output beat present.
- newBlockOut  out  1  newBlockIn of the accepted beat, delayed.
- hash  out  256  pseudo-hash.
- difficulty  out  32  leading-zero count of hash, 0..256, zero-extended.
- hit  out  1  validOut && difficulty >= target.
- hitCount  out  HCW  hits in current block, saturating.
- overrun  out  1  sticky: a validIn was presented while readyOut=0.

## Operation
- Fold: h = initialState[255:0] XOR {160'b0, initialState[351:256]}.
- LZC: count of consecutive zero bits from h[255] downward; h=0 gives 256. Computed on h before stage 1 and carried through the pipeline as 9 bits.
- Accept: accept = validIn && readyOut. Stage 1 captures valid=accept, newBlock=newBlockIn && accept, h and LZC. Stage k+1 copies stage k every cycle, so the pipeline never stalls.
- Outputs come from stage LATENCY.
- Data registers are loaded only when the incoming valid is 1; otherwise they hold. Hash and difficulty are don't-care while validOut=0, but are 0 after reset.
- II gate: a down-counter cnt. On accept with II>1, cnt loads II-1. readyOut = (cnt==0). cnt decrements while nonzero. For II=1, readyOut is constantly 1 after reset.
- Dropped beat: validIn=1 while readyOut=0 is discarded and sets overrun. overrun clears only on rst.
- hit is combinational from the stage-LATENCY registers and target.
- hitCount register, next value:
  - validOut && newBlockOut: next = hit (0 or 1).
  - else validOut && hit: next = min(hitCount+1, 2^HCW-1).
  - else: hold.

## Timing
- Reset values: readyOut=1, validOut=0, newBlockOut=0, hash=0, difficulty=0, hit=0, hitCount=0, overrun=0, cnt=0, all stage valids=0.
- Latency: a beat accepted at edge t appears on the outputs after edge t+LATENCY-1, i.e. valid for exactly one cycle.
- Throughput: one beat per II cycles. readyOut falls in the cycle after an accept and returns II-1 cycles later.
- hitCount reflects a hit one cycle after the hit beat.
- Simultaneous validOut, newBlockOut and hit: the count restarts at 1, not 0 plus 1 on the old count.
- Reset mid-operation: all in-flight beats are discarded immediately (asynchronous). No validOut pulse follows reset release until new beats are accepted.
- Back-to-back newBlockIn beats: each restarts the count.
- target changes are reflected on hit in the same cycle.

## Test plan
- LATENCY=10, II=1; one beat with initialState[255:0]=1 and [351:256]=0 at cycle 0 -> validOut=1 for one cycle at cycle 10, hash=1, difficulty=255; readyOut stays 1.
- initialState[255:0]=1 and [351:256]=96'h1 -> hash=0, difficulty=256, hit=1 for target=256. initialState[255]=1 -> difficulty=0, hit=1 only for target=0.
- II=4; validIn held high for 12 cycles -> exactly 3 beats accepted (cycles 0, 4, 8), readyOut pattern 1,0,0,0 repeating, overrun=1 from cycle 2 onward.
- target=8; 5 beats, the first with newBlock, all with difficulty>=8 -> hitCount reads 1..5. Then a newBlock beat with difficulty 3 -> hitCount 0. HCW=2 with 6 hits -> hitCount saturates at 3.
- Assert rst while 5 beats are in flight -> all outputs are immediately at reset values, and no validOut occurs within LATENCY cycles after release.
- LATENCY=1, II=1; continuous random stream -> each output equals the fold/LZC of the input one cycle earlier, and newBlockOut aligns with its beat.
